// File: rtl/bus_ctrl_if.sv
// bus_ctrl_if: CPU-side request/response bus and the synchronous SRAM port of bus_ctrl.
// The slave modport is the controller's view. The master modport is the CPU plus SRAM side.
interface bus_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] o_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  rd_en, wr_en, o_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output rd_en, wr_en, o_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/bus_ctrl.sv
// bus_ctrl: decodes CPU accesses into a 32 KiB synchronous SRAM window and a few MMIO registers.
// The MMIO registers are a UART transmitter (8N1) with a small TX FIFO, its status register,
// and an optional free-running timer.
// Define BUS_TIMER_EN to build the 32-bit timer at 0xFF08. Without it, that address is unmapped.
// Reads always complete one cycle after the request. MMIO values are captured in the request cycle,
// so they line up with the SRAM's registered output.
module bus_ctrl #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_ctrl_if.slave    bus,
    output logic         uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [13:0] UART_DATA_WORD = 14'h3FC0;
    localparam logic [13:0] UART_STAT_WORD = 14'h3FC1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    logic          is_ram;
    logic          is_uart_data;
    logic          is_uart_stat;
    logic          rd_fire;
    logic          addr_lsb_unused;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          fifo_empty, fifo_full;
    logic          push_req, push_ok, pop;
    logic [7:0]    fifo_head;

    logic          rd_valid_q, rd_valid_d;
    logic          rd_from_ram_q, rd_from_ram_d;
    logic [31:0]   mmio_q, mmio_d;

    tx_state_e     state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          uart_tx_q;
    logic          baud_end;
    logic          tx_busy;

    assign is_ram          = ~bus.o_addr[15];
    assign is_uart_data    = (bus.o_addr[15:2] == UART_DATA_WORD);
    assign is_uart_stat    = (bus.o_addr[15:2] == UART_STAT_WORD);
    assign addr_lsb_unused = ^bus.o_addr[1:0];

    assign bus.ram_addr  = bus.o_addr[14:2];
    assign bus.ram_wdata = bus.wr_data;
    assign bus.ram_we    = bus.wr_en & is_ram;

`ifdef BUS_TIMER_EN
    localparam logic [13:0] TIMER_WORD = 14'h3FC2;

    logic        is_timer;
    logic [31:0] timer_q, timer_d;

    assign is_timer = (bus.o_addr[15:2] == TIMER_WORD);

    // Free-running counter; wraps naturally at 32 bits and ignores bus writes.
    always_comb begin
        timer_d = timer_q + 32'd1;
    end

    // Timer register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign tx_busy    = (state_q != ST_IDLE);
    assign baud_end   = (baud_cnt_q == CW'(CLK_DIV - 1));

    // The shifter takes a byte when idle, or right at the end of a stop bit so frames run back to back.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));

    // FIFO pointer and overflow bookkeeping. A pop in the same cycle makes room for a push into a full FIFO.
    always_comb begin
        push_req   = bus.wr_en & is_uart_data;
        push_ok    = push_req & (~fifo_full | pop);
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q;
        if (bus.wr_en & is_uart_stat) begin
            overflow_d = 1'b0;
        end else if (push_req & ~push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO and overflow state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage. No reset is needed because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data[7:0];
    end

    // Read request capture. A write in the same cycle wins, so no response is produced.
    always_comb begin
        rd_fire       = bus.rd_en & ~bus.wr_en;
        rd_valid_d    = rd_fire;
        rd_from_ram_d = rd_fire & is_ram;
        mmio_d        = '0;
        if (rd_fire && is_uart_stat) begin
            mmio_d = {28'b0, overflow_q, fifo_full, fifo_empty, tx_busy};
        end
`ifdef BUS_TIMER_EN
        if (rd_fire && is_timer) begin
            mmio_d = timer_q;
        end
`endif
    end

    // Read response registers. Reset discards any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q    <= 1'b0;
            rd_from_ram_q <= 1'b0;
            mmio_q        <= '0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            rd_from_ram_q <= rd_from_ram_d;
            mmio_q        <= mmio_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_valid_q ? (rd_from_ram_q ? bus.ram_rdata : mmio_q) : 32'h0;

    // UART transmit FSM: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q    <= ST_START;
                        baud_cnt_q <= '0;
                        shift_q    <= fifo_head;
                        uart_tx_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        state_q    <= ST_DATA;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        uart_tx_q  <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q   <= ST_STOP;
                            uart_tx_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            uart_tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        if (pop) begin
                            state_q   <= ST_START;
                            shift_q   <= fifo_head;
                            uart_tx_q <= 1'b0;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    uart_tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = uart_tx_q;

endmodule
